sseg_scan: RTL and testbench

Time-multiplexed driver for an N-digit common-segment 7-segment display.
- Holds a shadow copy of N hex nibbles plus decimal points.
- Cycles one digit enable at a time, with a programmable dwell and an anti-ghosting dead time.
- Drives shared segment lines with optional leading-zero blanking, per-bus polarity inversion and tri-state output.
- Sits between a host register/counter block and the board display pins.

---
 rtl/sseg_pkg.sv | 29 ++
 rtl/sseg_decode.sv | 32 +++
 rtl/sseg_scan.sv | 193 +++++++++++++++++++
 tb/tb_sseg_scan.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
//   Shared constants for the multiplexed 7-segment display driver.
//   - SEG_A..SEG_G : output bit position of each physical segment.
//   - GLYPHS       : hex glyph table, stored in logical order
//                    (bit 0 = a ... bit 6 = g).
//   - SEG_OFF      : all segments dark.
// ---------------------------------------------------------------------------
package sseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Standard hex glyphs 0-9, A, b, C, d, E, F (logical a..g in bits 0..6).
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sseg_decode.sv
// ---------------------------------------------------------------------------
// sseg_decode
//   Combinational hex nibble to raw (active-high) segment decoder.
//   Ports:
//     nib_i  in  4  hex nibble
//     seg_o  out 7  segments, placed at the SEG_x positions of sseg_pkg
// ---------------------------------------------------------------------------
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  logic [6:0] glyph;

  // The table is kept in logical a..g order; each segment is routed to its
  // output bit through SEG_x so a board with a different pin order only
  // touches the package.
  always_comb begin
    glyph        = GLYPHS[nib_i];
    seg_o        = SEG_OFF;
    seg_o[SEG_A] = glyph[0];
    seg_o[SEG_B] = glyph[1];
    seg_o[SEG_C] = glyph[2];
    seg_o[SEG_D] = glyph[3];
    seg_o[SEG_E] = glyph[4];
    seg_o[SEG_F] = glyph[5];
    seg_o[SEG_G] = glyph[6];
  end

endmodule

// File: rtl/sseg_scan.sv
// ---------------------------------------------------------------------------
// sseg_scan
//   Time-multiplexed driver for an N-digit common-segment 7-segment display.
//   One digit is enabled per slot of CLK_DIV cycles; the last DEAD cycles of
//   every slot keep all digits dark to avoid ghosting. New display data is
//   staged and only copied into the shadow registers at a frame boundary so
//   a frame never mixes old and new digits.
//
//   Parameters:
//     DIGITS   number of digits (>=1), digit 0 least significant
//     CLK_DIV  clk cycles per digit slot (>=2)
//     DEAD     dark cycles at the end of each slot (0 <= DEAD < CLK_DIV)
//
//   Ports:
//     clk         in   1         rising-edge clock
//     rst_n       in   1         synchronous reset, active low
//     value       in   4*DIGITS  hex nibbles, nibble i = value[4i+3:4i]
//     dp          in   DIGITS    decimal point per digit
//     load        in   1         capture value/dp (applied at frame boundary)
//     blank_lz    in   1         leading-zero blanking enable
//     invert_seg  in   1         invert seg_q and dp_q
//     invert_dig  in   1         invert dig_q
//     oe          in   1         output enable, 0 tri-states seg_q/dp_q/dig_q
//     seg_q       out  7         segments g..a (bit 6 = g, bit 0 = a)
//     dp_q        out  1         decimal point segment
//     dig_q       out  DIGITS    one-hot digit enable
//     frame_done  out  1         one-cycle pulse when the scan wraps
// ---------------------------------------------------------------------------
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 1000,
  parameter int DEAD    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  invert_seg,
  input  logic                  invert_dig,
  input  logic                  oe,
  output logic [6:0]            seg_q,
  output logic                  dp_q,
  output logic [DIGITS-1:0]     dig_q,
  output logic                  frame_done
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ON_LEN = CLK_DIV - DEAD;

  // Scan control
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                load_pend_q, load_pend_d;
  logic                frame_done_q, frame_done_d;

  // Display data: staging (written by load) and shadow (what is shown)
  logic [4*DIGITS-1:0] stage_val_q;
  logic [DIGITS-1:0]   stage_dp_q;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

  // Registered raw (active-high, uninverted) outputs
  logic [6:0]          raw_seg_q, raw_seg_d;
  logic                raw_dp_q, raw_dp_d;
  logic [DIGITS-1:0]   raw_dig_q, raw_dig_d;

  logic                slot_wrap;
  logic                frame_wrap;
  logic                slot_on;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   lz_blank;
  logic                upper_zero;
  logic [6:0]          dec_seg;

  // ---- stage 0: slot counter, digit index, frame boundary ----
  assign slot_wrap  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign frame_wrap = slot_wrap && (idx_q == IDX_W'(DIGITS - 1));
  // Widened by one bit so ON_LEN == CLK_DIV (DEAD = 0) still compares right.
  assign slot_on    = ({1'b0, cnt_q} < (CNT_W + 1)'(ON_LEN));

  always_comb begin
    cnt_d = slot_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A load always wins over the boundary clear, so a load landing on the
  // boundary cycle stays pending for the following frame.
  always_comb begin
    load_pend_d  = load_pend_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (frame_wrap && load_pend_q) begin
      shadow_val_d = stage_val_q;
      shadow_dp_d  = stage_dp_q;
      load_pend_d  = 1'b0;
    end
    if (load) begin
      load_pend_d = 1'b1;
    end
  end

  assign frame_done_d = frame_wrap;

  // Digit i>0 is a leading zero when it and every higher nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (shadow_val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = upper_zero & (i != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = shadow_val_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blank = lz_blank[i];
      end
    end
  end

  sseg_decode u_decode (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  // ---- stage 1: registered raw segment / digit drive ----
  always_comb begin
    raw_seg_d = SEG_OFF;
    raw_dp_d  = 1'b0;
    raw_dig_d = '0;
    if (slot_on) begin
      raw_dig_d = DIGITS'(1) << idx_q;
      raw_seg_d = (blank_lz && cur_blank) ? SEG_OFF : dec_seg;
      raw_dp_d  = cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      load_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      raw_seg_q    <= SEG_OFF;
      raw_dp_q     <= 1'b0;
      raw_dig_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      load_pend_q  <= load_pend_d;
      frame_done_q <= frame_done_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      raw_seg_q    <= raw_seg_d;
      raw_dp_q     <= raw_dp_d;
      raw_dig_q    <= raw_dig_d;
    end
  end

  // Staging is pure data: stale contents are harmless because reset clears
  // load_pend, which is the only path from staging to shadow.
  always_ff @(posedge clk) begin
    if (load) begin
      stage_val_q <= value;
      stage_dp_q  <= dp;
    end
  end

  // ---- output stage: polarity and tri-state, combinational ----
  assign seg_q      = oe ? (raw_seg_q ^ {7{invert_seg}})        : 7'bzzzzzzz;
  assign dp_q       = oe ? (raw_dp_q ^ invert_seg)              : 1'bz;
  assign dig_q      = oe ? (raw_dig_q ^ {DIGITS{invert_dig}})   : {DIGITS{1'bz}};
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan
//   Scoreboard bench for sseg_scan with DIGITS=4, CLK_DIV=8, DEAD=2.
//   The stimulus process schedules expected outputs against an absolute
//   cycle number; the monitor samples 1 time unit after every rising edge
//   and compares any entry due on that cycle.
//   After reset release, the sample following edge k shows the raw state
//   computed from counter state k-1: digit ((k-1)/8)%4, slot cycle (k-1)%8,
//   and frame_done is high for k a multiple of 32.
// ---------------------------------------------------------------------------
module tb_sseg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic        invert_seg;
  logic        invert_dig;
  logic        oe;
  wire  [6:0]  seg_q;
  wire         dp_q;
  wire  [3:0]  dig_q;
  wire         frame_done;

  sseg_scan #(.DIGITS(4), .CLK_DIV(8), .DEAD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .blank_lz   (blank_lz),
    .invert_seg (invert_seg),
    .invert_dig (invert_dig),
    .oe         (oe),
    .seg_q      (seg_q),
    .dp_q       (dp_q),
    .dig_q      (dig_q),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int abs_cyc = 0;
  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  typedef struct {
    int         tag;
    string      name;
    bit         exp_z;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   base = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   rst_done = 1'b0;

  function automatic void push(string nm, int tag, logic [6:0] s, logic d,
                               logic [3:0] g, logic f, bit z);
    exp_t e;
    e.tag = tag; e.name = nm; e.exp_z = z;
    e.seg = s; e.dp = d; e.dig = g; e.fd = f;
    sb.push_back(e);
  endfunction

  // Expectation k edges after the most recent reset release.
  function automatic void expk(string nm, int k, logic [6:0] s, logic d, logic [3:0] g);
    push(nm, base + k, s, d, g, (k > 0) && (k % 32 == 0), 1'b0);
  endfunction

  function automatic void expz(string nm, int k);
    push(nm, base + k, 7'h00, 1'b0, 4'h0, (k > 0) && (k % 32 == 0), 1'b1);
  endfunction

  task automatic wait_neg(int k);
    while (abs_cyc < base + k) @(negedge clk);
  endtask

  // Load sampled on edge k.
  task automatic load_at(int k, logic [15:0] v, logic [3:0] d);
    wait_neg(k - 1);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic do_reset();
    int t;
    @(negedge clk);
    rst_n = 1'b0;
    t = abs_cyc;
    push("reset_state", t + 2, 7'h00, 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    base  = abs_cyc;
    rst_n = 1'b1;
    rst_done = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      #1;
      if (rst_done && oe && !invert_dig) begin
        n_chk++;
        if ($onehot0(dig_q)) n_pass++;
        else $display("FAIL dig_onehot cyc=%0d: got dig=%b, want at most one bit set", abs_cyc, dig_q);
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        e = sb[i];
        if (e.tag == abs_cyc) begin
          if (e.exp_z)
            ok = (seg_q === 7'bzzzzzzz) && (dp_q === 1'bz) && (dig_q === 4'bzzzz) &&
                 (frame_done === e.fd);
          else
            ok = (seg_q === e.seg) && (dp_q === e.dp) && (dig_q === e.dig) &&
                 (frame_done === e.fd);
          n_chk++;
          if (ok) n_pass++;
          else $display("FAIL %s cyc=%0d: got seg=%b dp=%b dig=%b fd=%b, want seg=%b dp=%b dig=%b fd=%b hiz=%0d",
                        e.name, abs_cyc, seg_q, dp_q, dig_q, frame_done,
                        e.seg, e.dp, e.dig, e.fd, e.exp_z);
          sb.delete(i);
        end else if (e.tag < abs_cyc) begin
          n_chk++;
          $display("FAIL %s: got no sample at cyc %0d, want one", e.name, e.tag);
          sb.delete(i);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; value = 16'h0; dp = 4'h0; load = 1'b0;
    blank_lz = 1'b0; invert_seg = 1'b0; invert_dig = 1'b0; oe = 1'b1;
    do_reset();

    // Reset release, frame cadence, dead time
    expk("first_on_d0",   1, 7'h3F, 1'b0, 4'b0001);
    expk("f0_dead_end",  31, 7'h00, 1'b0, 4'b0000);
    expk("fd_frame0",    32, 7'h00, 1'b0, 4'b0000);
    expk("f0_after_fd",  33, 7'h3F, 1'b0, 4'b0001);
    // Load 12AF mid-frame: frame 1 still shows zeros
    expk("preload_d1",   41, 7'h3F, 1'b0, 4'b0010);
    expk("preload_d3",   57, 7'h3F, 1'b0, 4'b1000);
    expk("fd_frame1",    64, 7'h00, 1'b0, 4'b0000);
    expk("new_d0_F",     65, 7'h71, 1'b0, 4'b0001);
    expk("d0_last_on",   70, 7'h71, 1'b0, 4'b0001);
    expk("d0_dead6",     71, 7'h00, 1'b0, 4'b0000);
    expk("d0_dead7",     72, 7'h00, 1'b0, 4'b0000);
    expk("new_d1_A",     73, 7'h77, 1'b0, 4'b0010);
    expk("new_d2_2_dp",  81, 7'h5B, 1'b1, 4'b0100);
    expk("new_d3_1",     89, 7'h06, 1'b0, 4'b1000);
    // Leading-zero blanking on 0050 (dp on digit 3), then 0000
    expk("lz_d0_0",      97, 7'h3F, 1'b0, 4'b0001);
    expk("lz_d1_5",     105, 7'h6D, 1'b0, 4'b0010);
    expk("lz_d2_blank", 113, 7'h00, 1'b0, 4'b0100);
    expk("lz_d3_dp",    121, 7'h00, 1'b1, 4'b1000);
    expk("fd_frame3",   128, 7'h00, 1'b0, 4'b0000);
    expk("lz0_d0",      129, 7'h3F, 1'b0, 4'b0001);
    expk("lz0_d1",      137, 7'h00, 1'b0, 4'b0010);
    expk("lz0_d3",      153, 7'h00, 1'b0, 4'b1000);
    // Inversion on digit0 = 8, then tri-state
    expk("inv_on_d0",   161, 7'h00, 1'b1, 4'b1110);
    expk("inv_dead",    167, 7'h7F, 1'b1, 4'b1111);
    expk("inv_d1_blank",169, 7'h7F, 1'b1, 4'b1101);
    expz("oe_off",      180);
    expz("oe_off_fd",   192);
    expk("oe_back_d0",  193, 7'h7F, 1'b0, 4'b0001);
    // Two loads in one frame: latest wins at the next boundary
    expk("two_load_old",217, 7'h3F, 1'b0, 4'b1000);
    expk("two_load_d0", 225, 7'h5B, 1'b0, 4'b0001);
    expk("two_load_d3", 249, 7'h5B, 1'b0, 4'b1000);
    expk("fd_frame7",   256, 7'h00, 1'b0, 4'b0000);

    load_at(40, 16'h12AF, 4'b0100);
    wait_neg(89);
    blank_lz = 1'b1;
    load_at(90, 16'h0050, 4'b1000);
    load_at(110, 16'h0000, 4'b0000);
    load_at(140, 16'h0008, 4'b0000);
    wait_neg(160);
    invert_seg = 1'b1;
    invert_dig = 1'b1;
    wait_neg(175);
    oe = 1'b0;
    wait_neg(192);
    oe = 1'b1;
    invert_seg = 1'b0;
    invert_dig = 1'b0;
    blank_lz = 1'b0;
    load_at(200, 16'h1111, 4'b0000);
    load_at(210, 16'h2222, 4'b0000);

    // Pending loads then reset mid-frame: shadow zero, pending discarded
    load_at(260, 16'h1111, 4'b0000);
    load_at(270, 16'h2222, 4'b0000);
    wait_neg(275);
    do_reset();
    expk("rst2_first_on", 1, 7'h3F, 1'b0, 4'b0001);
    expk("rst2_f1_d0",   33, 7'h3F, 1'b0, 4'b0001);
    expk("rst2_f1_d3",   57, 7'h3F, 1'b0, 4'b1000);
    // Load on the boundary edge itself waits one more frame
    expk("bnd_not_yet",  65, 7'h3F, 1'b0, 4'b0001);
    expk("fd_rst2_f2",   96, 7'h00, 1'b0, 4'b0000);
    expk("bnd_applied",  97, 7'h4F, 1'b0, 4'b0001);
    load_at(64, 16'h3333, 4'b0000);

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      n_chk++;
      $display("FAIL %s: got no sample before timeout, want one at cyc %0d", sb[0].name, sb[0].tag);
      sb.delete(0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
